// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Active-low cathode pattern to BCD digit; valid is low for non-digit shapes.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] cathode_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o = '0;
    unique case (cathode_i)
      SEG_0:   dec_o = '{valid: 1'b1, digit: 4'd0};
      SEG_1:   dec_o = '{valid: 1'b1, digit: 4'd1};
      SEG_2:   dec_o = '{valid: 1'b1, digit: 4'd2};
      SEG_3:   dec_o = '{valid: 1'b1, digit: 4'd3};
      SEG_4:   dec_o = '{valid: 1'b1, digit: 4'd4};
      SEG_5:   dec_o = '{valid: 1'b1, digit: 4'd5};
      SEG_6:   dec_o = '{valid: 1'b1, digit: 4'd6};
      SEG_7:   dec_o = '{valid: 1'b1, digit: 4'd7};
      SEG_8:   dec_o = '{valid: 1'b1, digit: 4'd8};
      SEG_9:   dec_o = '{valid: 1'b1, digit: 4'd9};
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors the multiplexed seven-segment scan and rebuilds the displayed BCD value.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_anode,
  input  logic [6:0]  seg_cathode,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        frame_done,
  output logic        pat_err,
  output logic        anode_err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [10:0] s1_q, s2_q, p_q;
  logic [7:0]  cnt_q, cnt_d;
  scan_state_e state_q, state_d;
  logic [15:0] shadow_q, shadow_d, shadow_n;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  seen_q, seen_d, seen_n;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;
  logic        aerr_q, aerr_d;
  logic        cap;
  logic [3:0]  an_low;
  logic        multi, single;
  logic [1:0]  idx;
  seg_dec_t    dec;

  seg_pattern_decode u_dec (
    .cathode_i(s2_q[6:0]),
    .dec_o    (dec)
  );

  assign an_low = ~s2_q[10:7];
  assign multi  = (an_low & (an_low - 4'd1)) != 4'd0;
  assign single = (an_low != 4'd0) && !multi;

  always_comb begin
    idx = 2'd0;
    unique case (an_low)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // One capture per stable window: HELD parks until the sample changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (s2_q != p_q) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == STABLE) begin
        cap     = 1'b1;
        state_d = HELD;
      end
    end
  end

  always_comb begin
    shadow_n = shadow_q;
    shadow_n[{idx, 2'b00} +: 4] = dec.digit;
    seen_n   = seen_q | (4'b0001 << idx);
    shadow_d = shadow_q;
    seen_d   = seen_q;
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    aerr_d   = 1'b0;
    if (cap && multi) begin
      aerr_d = 1'b1;
    end else if (cap && single && !dec.valid) begin
      perr_d = 1'b1;
    end else if (cap && single) begin
      shadow_d = shadow_n;
      seen_d   = seen_n;
      if (seen_n == 4'hF) begin
        bcd_d   = shadow_n;
        done_d  = 1'b1;
        valid_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      state_q  <= SETTLE;
      shadow_q <= '0;
      seen_q   <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      s1_q     <= {seg_anode, seg_cathode};
      s2_q     <= s1_q;
      p_q      <= s2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign bcd_valid  = valid_q;
  assign frame_done = done_q;
  assign pat_err    = perr_q;
  assign anode_err  = aerr_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment bus.
- Samples the anode/cathode scan signals and reconstructs the 16-bit BCD value being displayed, one digit per scan slot.
- Publishes the complete value once all four digits have been captured.
- Used as the loopback/monitor end of the display path, so the board and bench can check what the display actually shows.

Parameters:
- STABLE_CYCLES, 4: consecutive equal synchronized samples required before a scan slot is accepted (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- seg_anode  input  4  digit enables, active-low; bit 0 = rightmost digit = bcd_out[3:0], bit 3 = bcd_out[15:12]
- seg_cathode  input  7  segments, active-low; bit 0 = a … bit 6 = g
- bcd_out  output  16  last complete reconstructed value, 4 BCD nibbles
- bcd_valid  output  1  high once the first complete frame has been published
- frame_done  output  1  one-cycle pulse when bcd_out updates
- pat_err  output  1  one-cycle pulse: accepted slot had an undecodable cathode pattern
- anode_err  output  1  one-cycle pulse: accepted slot had more than one anode low

Behaviour:
- Reset (async, active-high) clears all of the following to 0: sync flops, previous-sample register, counter, shadow digits, seen mask, bcd_out, bcd_valid, frame_done, pat_err, anode_err. FSM goes to SETTLE.
- Input path:
  - The 11-bit {anode, cathode} vector passes through a 2-flop synchronizer to give s2.
  - Register p holds s2 delayed one cycle.
  - Every edge: if s2 != p, cnt <= 0 and FSM -> SETTLE.
- FSM:
  - SETTLE: if s2 == p, cnt++. When cnt reaches STABLE_CYCLES, a capture event occurs on that edge and FSM -> HELD.
  - HELD: no further captures; leave only on a change (s2 != p -> SETTLE, cnt = 0).
  - Result: exactly one capture per stable window, however long the window lasts.
- Latency: the capture takes effect at rising edge STABLE_CYCLES+3 after the pins change (2 sync + 1 compare + STABLE_CYCLES). A window shorter than that produces no capture.
- Capture event handling:
  - Anode 4'b1111 (blank): no action, no error.
  - More than one anode bit low: anode_err pulse, no state change.
  - Exactly one anode low, index i: decode the cathode pattern.
    - Active-high segment sets: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
    - Match: shadow[i] <= digit and seen[i] <= 1.
    - No match: pat_err pulse; shadow[i] and seen[i] unchanged.
  - A repeated digit within a frame overwrites shadow[i]; the seen mask is unchanged.
- Frame completion:
  - When seen becomes 4'b1111 on a capture edge (including the capture setting the last bit), bcd_out <= shadow, with the newly captured nibble included.
  - On that same edge: frame_done pulses, bcd_valid <= 1, seen <= 0.
  - bcd_out holds between frames. bcd_valid stays high until reset.
- Outputs are registered; pulses are exactly one cycle wide.
- Reset mid-frame discards all partial digits; the next frame needs all four captures.

Decomposition:
- Shared package seg_pkg:
  - SEG_0..SEG_9 active-low 7-bit cathode constants, shared with the display encoder so both ends agree.
  - ANODE_BLANK = 4'b1111.
  - FSM state typedef (SETTLE, HELD).
- One combinational sub-module, seg_pattern_decode: cathode[6:0] -> {valid, digit[3:0]}. Keeps the top module to synchronizer, counter, FSM and frame assembly.

Test Plan:
- Reset: assert rst mid-clock with random pins -> all outputs 0 immediately; stay 0 for 20 cycles with pins at 4'b1111/7'b1111111.
- Normal frame: STABLE_CYCLES=4; drive anode 0111/SEG_1, 1011/SEG_2, 1101/SEG_3, 1110/SEG_4, each 10 cycles -> single frame_done exactly 7 edges after the 4th digit starts; bcd_out=16'h1234; bcd_valid=1.
- Glitch rejection: hold anode 1110/SEG_5 for 6 cycles, then change -> no capture. Hold for 7 cycles -> capture. Verify via frame completion value.
- Bad pattern: anode 1110 with cathode 7'b0000110 held 10 cycles -> one pat_err pulse; the frame does not complete until a valid digit 0 arrives.
- Anode faults: anode 1100 held 10 cycles -> one anode_err pulse, no capture. Anode 1111 -> no pulses.
- Reset mid-frame then refresh: capture digits 3 and 2, pulse rst, then scan 9,8,7,6 -> bcd_out=16'h9876 with a single frame_done. Next, repeat digit 0 twice within a frame (5 then 6) -> the published nibble is 6.
